// File: rtl/alu_operand_fetch_pkg.sv
// Shared definitions for the ALU operand-fetch stage: addressing modes,
// command field positions and FSM state encodings.
package alu_operand_fetch_pkg;

  localparam int CMD_W   = 32;
  localparam int FIELD_W = 8;

  localparam int CMD_OP_MSB = 31;
  localparam int CMD_OP_LSB = 28;
  localparam int CMD_M1_MSB = 27;
  localparam int CMD_M1_LSB = 26;
  localparam int CMD_M0_MSB = 25;
  localparam int CMD_M0_LSB = 24;
  localparam int CMD_F1_MSB = 23;
  localparam int CMD_F1_LSB = 16;
  localparam int CMD_F0_MSB = 15;
  localparam int CMD_F0_LSB = 8;

  typedef enum logic [1:0] {
    AM_IMM = 2'd0,
    AM_DIR = 2'd1,
    AM_IND = 2'd2,
    AM_RSV = 2'd3
  } am_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUS    = 3'd1,
    ST_S0_PTR = 3'd2,
    ST_S0     = 3'd3,
    ST_S1_PTR = 3'd4,
    ST_S1     = 3'd5,
    ST_DONE   = 3'd6
  } of_state_e;

  // The bus is owned from the grant wait through the last read.
  function automatic logic is_bus_state(input of_state_e s);
    return (s == ST_BUS) || (s == ST_S0_PTR) || (s == ST_S0) ||
           (s == ST_S1_PTR) || (s == ST_S1);
  endfunction

endpackage

// File: rtl/alu_operand_fetch_addr_mode_dec.sv
// Combinational decode of one operand's addressing mode and 8-bit field into
// read requirements, immediate value and register-window address.
module of_addr_mode_dec
  import alu_operand_fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] REG_BASE = '0
) (
  input  am_e                mode_i,
  input  logic [FIELD_W-1:0] field_i,
  output logic               needs_read_o,
  output logic               needs_ptr_o,
  output logic               rsv_o,
  output logic [DATA_W-1:0]  imm_value_o,
  output logic [ADDR_W-1:0]  addr_o
);

  assign needs_read_o = (mode_i == AM_DIR) || (mode_i == AM_IND);
  assign needs_ptr_o  = (mode_i == AM_IND);
  assign rsv_o        = (mode_i == AM_RSV);

  // Reserved mode yields a zero operand; read modes overwrite this later.
  assign imm_value_o  = (mode_i == AM_IMM) ? DATA_W'($signed(field_i)) : '0;

  assign addr_o       = REG_BASE + ADDR_W'(field_i);

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage ahead of the ALU: decodes src0/src1 addressing, owns the
// memory bus for direct/indirect reads and presents registered operands.
//
// state  | meaning
// IDLE   | waiting for start
// BUS    | bus_req high, waiting for bus_gnt
// S0_PTR | reading src0 pointer from register window
// S0     | reading src0 value (direct or via pointer)
// S1_PTR | reading src1 pointer from register window
// S1     | reading src1 value (direct or via pointer)
// DONE   | one-cycle done pulse, operands valid
module alu_operand_fetch
  import alu_operand_fetch_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] REG_BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CMD_W-1:0]  command,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] src0,
  output logic [DATA_W-1:0] src1,
  output logic              done,
  output logic              err,
  output logic              busy
);

  of_state_e           state_q, state_d;
  am_e                 m0_q, m1_q;
  logic [FIELD_W-1:0]  f0_q, f1_q;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   data0_q, data0_d;
  logic [DATA_W-1:0]   data1_q, data1_d;
  logic [DATA_W-1:0]   src0_q, src1_q;
  logic                err_q;

  logic                idle;
  am_e                 mode0, mode1;
  logic [FIELD_W-1:0]  field0, field1;
  logic                rd0, rd1, ptr0, ptr1, rsv0, rsv1;
  logic [DATA_W-1:0]   imm0, imm1;
  logic [ADDR_W-1:0]   addr0, addr1;
  of_state_e           after_s0;
  logic                rd_act;
  logic [ADDR_W-1:0]   rd_addr;
  logic                ack_ok;
  logic                unused_cmd;

  assign idle = (state_q == ST_IDLE);

  // While idle the live command is decoded so the start cycle can branch;
  // afterwards only the latched fields are used.
  assign mode0  = idle ? am_e'(command[CMD_M0_MSB:CMD_M0_LSB]) : m0_q;
  assign mode1  = idle ? am_e'(command[CMD_M1_MSB:CMD_M1_LSB]) : m1_q;
  assign field0 = idle ? command[CMD_F0_MSB:CMD_F0_LSB] : f0_q;
  assign field1 = idle ? command[CMD_F1_MSB:CMD_F1_LSB] : f1_q;

  assign unused_cmd = ^{command[CMD_OP_MSB:CMD_OP_LSB], command[CMD_F0_LSB-1:0]};

  of_addr_mode_dec #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .REG_BASE (REG_BASE)
  ) u_dec0 (
    .mode_i       (mode0),
    .field_i      (field0),
    .needs_read_o (rd0),
    .needs_ptr_o  (ptr0),
    .rsv_o        (rsv0),
    .imm_value_o  (imm0),
    .addr_o       (addr0)
  );

  of_addr_mode_dec #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .REG_BASE (REG_BASE)
  ) u_dec1 (
    .mode_i       (mode1),
    .field_i      (field1),
    .needs_read_o (rd1),
    .needs_ptr_o  (ptr1),
    .rsv_o        (rsv1),
    .imm_value_o  (imm1),
    .addr_o       (addr1)
  );

  assign after_s0 = rd1 ? (ptr1 ? ST_S1_PTR : ST_S1) : ST_DONE;
  assign ack_ok   = bus_gnt && mem_ack;

  always_comb begin
    state_d = state_q;
    data0_d = data0_q;
    data1_d = data1_q;
    ptr_d   = ptr_q;
    rd_act  = 1'b0;
    rd_addr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          data0_d = imm0;
          data1_d = imm1;
          state_d = (rd0 || rd1) ? ST_BUS : ST_DONE;
        end
      end
      ST_BUS: begin
        if (bus_gnt) begin
          state_d = rd0 ? (ptr0 ? ST_S0_PTR : ST_S0) : after_s0;
        end
      end
      ST_S0_PTR: begin
        rd_act  = 1'b1;
        rd_addr = addr0;
        if (ack_ok) begin
          ptr_d   = ADDR_W'(mem_rdata);
          state_d = ST_S0;
        end
      end
      ST_S0: begin
        rd_act  = 1'b1;
        rd_addr = ptr0 ? ptr_q : addr0;
        if (ack_ok) begin
          data0_d = mem_rdata;
          state_d = after_s0;
        end
      end
      ST_S1_PTR: begin
        rd_act  = 1'b1;
        rd_addr = addr1;
        if (ack_ok) begin
          ptr_d   = ADDR_W'(mem_rdata);
          state_d = ST_S1;
        end
      end
      ST_S1: begin
        rd_act  = 1'b1;
        rd_addr = ptr1 ? ptr_q : addr1;
        if (ack_ok) begin
          data1_d = mem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m0_q    <= AM_IMM;
      m1_q    <= AM_IMM;
      f0_q    <= '0;
      f1_q    <= '0;
      ptr_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
      src0_q  <= '0;
      src1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      if (idle && start) begin
        m0_q <= mode0;
        m1_q <= mode1;
        f0_q <= field0;
        f1_q <= field1;
      end
      // DONE is only ever entered for one cycle, so this publishes once per fetch.
      if (state_d == ST_DONE) begin
        src0_q <= data0_d;
        src1_q <= data1_d;
        err_q  <= rsv0 || rsv1;
      end
    end
  end

  assign bus_req  = is_bus_state(state_q);
  assign mem_rd   = rd_act && bus_gnt;
  assign mem_addr = rd_addr;
  assign src0     = src0_q;
  assign src1     = src1_q;
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;
  assign busy     = !idle;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench for alu_operand_fetch: memory/bus responder, behavioural
// operand model and a per-cycle compare process.
module tb_alu_operand_fetch;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] command;
  logic        bus_req, bus_gnt;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_ack;
  logic [31:0] mem_rdata, src0, src1;
  logic        done, err, busy;

  alu_operand_fetch #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .REG_BASE (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .command   (command),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .src0      (src0),
    .src1      (src1),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pe = 0;
  int p0 = 0;
  bit active = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log [$];
  logic [31:0] exp_rd [$];
  int          gnt_delay, ack_delay, req_cnt, rd_cnt;
  logic [31:0] exp_s0, exp_s1, prev_s0, prev_s1;
  bit          exp_err;
  int          exp_lat;
  int          obs_lat;
  logic [31:0] obs_s0, obs_s1;
  logic        obs_err;
  logic        prev_rd;
  logic [31:0] prev_addr;

  always @(posedge clk) pe++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] mk(input logic [1:0] m0, input logic [7:0] f0,
                                     input logic [1:0] m1, input logic [7:0] f1);
    return {4'h3, m1, m0, f1, f0, 8'h00};
  endfunction

  // Operand semantics straight from the addressing-mode rules.
  task automatic model_operand(input logic [1:0] m, input logic [7:0] f,
                               output logic [31:0] v, inout bit e);
    logic [31:0] a, p;
    a = BASE + {24'h0, f};
    case (m)
      2'd0: v = {{24{f[7]}}, f};
      2'd1: begin exp_rd.push_back(a); v = rd_mem(a); end
      2'd2: begin
        exp_rd.push_back(a);
        p = rd_mem(a);
        exp_rd.push_back(p);
        v = rd_mem(p);
      end
      default: begin v = 32'h0; e = 1'b1; end
    endcase
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_src0"}, src0, 0);
    chk({tag, "_src1"}, src1, 0);
  endtask

  task automatic run_fetch(input logic [31:0] cmd, input int gd, input int ad, input bit extra);
    bit e;
    e = 1'b0;
    exp_rd.delete();
    rd_log.delete();
    model_operand(cmd[25:24], cmd[15:8], exp_s0, e);
    model_operand(cmd[27:26], cmd[23:16], exp_s1, e);
    exp_err = e;
    exp_lat = (exp_rd.size() == 0) ? 1 : 2 + gd + exp_rd.size() * (ad + 1);
    gnt_delay = gd;
    ack_delay = ad;
    obs_lat = -1;
    @(posedge clk); #1;
    command = cmd;
    start = 1'b1;
    p0 = pe;
    active = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    command = ~cmd;
    while (active && (pe - p0) < exp_lat + 30) begin
      if (extra && ((pe - p0) == 1 || (pe - p0) == exp_lat)) begin
        command = mk(2'd0, 8'h01, 2'd0, 8'h02);
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("timeout", active, 0);
    active = 1'b0;
  endtask

  // Compare process, then the bus/memory responder for the next half cycle.
  always @(negedge clk) begin
    int rel;
    if (active) begin
      rel = pe - p0;
      chk("done", done, rel == exp_lat);
      chk("busy", busy, rel >= 1 && rel <= exp_lat);
      chk("bus_req", bus_req, rel >= 1 && rel < exp_lat && exp_rd.size() > 0);
      if (prev_rd && !mem_ack) begin
        chk("rd_hold", mem_rd, 1);
        chk("addr_hold", mem_addr, prev_addr);
      end
      if (rel == exp_lat) begin
        chk("src0", src0, exp_s0);
        chk("src1", src1, exp_s1);
        chk("err", err, exp_err);
        chk("nreads", rd_log.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
          chk("rd_addr", rd_log[i], exp_rd[i]);
      end else if (rel < exp_lat) begin
        chk("src0_hold", src0, prev_s0);
        chk("src1_hold", src1, prev_s1);
      end
      if (done) begin
        obs_lat = rel;
        obs_s0 = src0;
        obs_s1 = src1;
        obs_err = err;
      end
      if (rel >= exp_lat + 2) begin
        active = 1'b0;
        prev_s0 = exp_s0;
        prev_s1 = exp_s1;
      end
    end
    prev_rd = mem_rd;
    prev_addr = mem_addr;

    if (bus_req) begin
      if (req_cnt >= gnt_delay) bus_gnt = 1'b1;
      req_cnt++;
    end else begin
      bus_gnt = 1'b0;
      req_cnt = 0;
    end
    if (mem_rd) begin
      if (rd_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = rd_mem(mem_addr);
        rd_log.push_back(mem_addr);
        rd_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        rd_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      rd_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; command = 32'h0;
    bus_gnt = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    gnt_delay = 0; ack_delay = 0; req_cnt = 0; rd_cnt = 0;
    prev_rd = 1'b0; prev_addr = 32'h0; prev_s0 = 32'h0; prev_s1 = 32'h0;
    mem[BASE + 32'h3]  = 32'hDEAD_BEEF;
    mem[BASE + 32'h1]  = 32'h0000_2000;
    mem[32'h0000_2000] = 32'h0000_0011;
    mem[BASE + 32'h2]  = 32'h0000_0022;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Both immediate: no bus, done one cycle after start.
    run_fetch(mk(2'd0, 8'hFE, 2'd0, 8'h05), 0, 0, 0);
    chk("t1_lat", obs_lat, 1);
    chk("t1_src0", obs_s0, 32'hFFFF_FFFE);
    chk("t1_src1", obs_s1, 32'h0000_0005);
    chk("t1_err", obs_err, 0);

    // Direct src0, immediate src1.
    run_fetch(mk(2'd1, 8'h03, 2'd0, 8'h07), 0, 0, 0);
    chk("t2_lat", obs_lat, 3);
    chk("t2_src0", obs_s0, 32'hDEAD_BEEF);
    chk("t2_src1", obs_s1, 32'h0000_0007);
    chk("t2_nrd", rd_log.size(), 1);
    if (rd_log.size() == 1) chk("t2_addr", rd_log[0], 32'h0000_0103);

    // Indirect src0 then direct src1.
    run_fetch(mk(2'd2, 8'h01, 2'd1, 8'h02), 0, 0, 0);
    chk("t3_lat", obs_lat, 5);
    chk("t3_src0", obs_s0, 32'h0000_0011);
    chk("t3_src1", obs_s1, 32'h0000_0022);
    chk("t3_nrd", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("t3_a0", rd_log[0], 32'h0000_0101);
      chk("t3_a1", rd_log[1], 32'h0000_2000);
      chk("t3_a2", rd_log[2], 32'h0000_0102);
    end

    // Same as direct case with slow grant and slow ack.
    run_fetch(mk(2'd1, 8'h03, 2'd0, 8'h07), 4, 3, 0);
    chk("t4_lat", obs_lat, 10);
    chk("t4_src0", obs_s0, 32'hDEAD_BEEF);

    // Reserved src1 with stray start pulses during the fetch and in DONE.
    run_fetch(mk(2'd1, 8'h03, 2'd3, 8'h44), 0, 0, 1);
    chk("t5_lat", obs_lat, 3);
    chk("t5_src1", obs_s1, 32'h0);
    chk("t5_err", obs_err, 1);

    // Immediate src0 (negative), indirect src1 taken straight from BUS.
    run_fetch(mk(2'd0, 8'h80, 2'd2, 8'h01), 1, 1, 0);
    chk("t7_lat", obs_lat, 7);
    chk("t7_src0", obs_s0, 32'hFFFF_FF80);
    chk("t7_src1", obs_s1, 32'h0000_0011);

    // Reset while S0 waits for ack.
    gnt_delay = 0;
    ack_delay = 20;
    @(posedge clk); #1;
    command = mk(2'd1, 8'h03, 2'd1, 8'h02);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("t6_rd_pending", mem_rd, 1);
    chk("t6_addr_pending", mem_addr, 32'h0000_0103);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("t6");
    prev_s0 = 32'h0;
    prev_s1 = 32'h0;

    run_fetch(mk(2'd2, 8'h01, 2'd1, 8'h02), 0, 0, 0);
    chk("t6b_src0", obs_s0, 32'h0000_0011);
    chk("t6b_src1", obs_s1, 32'h0000_0022);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
